muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide engine in the EX stage of the MIPS pipeline.
- It produces the HI/LO result pair for MULT, MULTU, DIV and DIVU and drives the write side of the HI/LO register.
- While it is busy it asserts a stall so the pipeline holds.
- When a result completes it presents hi/lo with a one-cycle write strobe.

---
 rtl/muldiv_unit.sv | 133 +++++++++++++
 tb/tb_muldiv_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide engine for the EX stage: single-edge multiply, restoring radix-2 divide.
// busy doubles as the pipeline stall request; result_valid is the HI/LO write strobe.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for start; hi_out/lo_out hold the last result
//   MUL    | operand magnitudes latched, product written next edge
//   DIV    | one restoring quotient bit per edge, MSB first
//   FIX    | sign correction of quotient/remainder and writeback
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;
    localparam int         CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [1:0]         state;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   b_mag;
    logic               q_neg;
    logic               r_neg;
    logic [CW-1:0]      count;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_abs;
    logic [WIDTH-1:0]   b_abs;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_fix;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     trial;
    logic               take;

    // quo doubles as the multiplicand register so MUL and DIV share one operand latch
    assign a_neg       = ~op[0] & src_a[WIDTH-1];
    assign b_neg       = ~op[0] & src_b[WIDTH-1];
    assign a_abs       = a_neg ? -src_a : src_a;
    assign b_abs       = b_neg ? -src_b : src_b;
    assign product     = {{WIDTH{1'b0}}, quo} * {{WIDTH{1'b0}}, b_mag};
    assign product_fix = q_neg ? -product : product;
    assign shifted     = {rem, quo[WIDTH-1]};
    assign trial       = shifted - {1'b0, b_mag};
    assign take        = ~trial[WIDTH];
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            quo          <= '0;
            rem          <= '0;
            b_mag        <= '0;
            q_neg        <= 1'b0;
            r_neg        <= 1'b0;
            count        <= '0;
            result_valid <= 1'b0;
            hi_out       <= '0;
            lo_out       <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !cancel) begin
                        count <= '0;
                        rem   <= '0;
                        if (op[1] && (src_b == '0)) begin
                            // divide by zero skips iteration; raw dividend becomes remainder
                            quo   <= '1;
                            rem   <= src_a;
                            b_mag <= src_b;
                            q_neg <= 1'b0;
                            r_neg <= 1'b0;
                            state <= S_FIX;
                        end else begin
                            quo   <= a_abs;
                            b_mag <= b_abs;
                            q_neg <= a_neg ^ b_neg;
                            r_neg <= a_neg;
                            state <= op[1] ? S_DIV : S_MUL;
                        end
                    end
                end
                S_MUL: begin
                    if (cancel) begin
                        state <= S_IDLE;
                    end else begin
                        {hi_out, lo_out} <= product_fix;
                        result_valid     <= 1'b1;
                        state            <= S_IDLE;
                    end
                end
                S_DIV: begin
                    if (cancel) begin
                        state <= S_IDLE;
                    end else begin
                        rem   <= take ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
                        quo   <= {quo[WIDTH-2:0], take};
                        count <= count + CW'(1);
                        if (count == CW'(WIDTH - 1))
                            state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (cancel) begin
                        state <= S_IDLE;
                    end else begin
                        lo_out       <= q_neg ? -quo : quo;
                        hi_out       <= r_neg ? -rem : rem;
                        result_valid <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model plus cycle-level compare and literal pins.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        cancel;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        result_valid;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    bit          m_busy;
    bit          m_valid;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [63:0] m_pend;
    int          m_left;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .src_a        (src_a),
        .src_b        (src_b),
        .cancel       (cancel),
        .busy         (busy),
        .result_valid (result_valid),
        .hi_out       (hi_out),
        .lo_out       (lo_out)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // {hi, lo} from plain arithmetic on the architectural operands
    function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, p, q, r;
        logic [63:0] u;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: begin p = sa * sb; return 64'(p); end
            2'b01: begin u = {32'b0, a} * {32'b0, b}; return u; end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (o == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    return {r[31:0], q[31:0]};
                end
                return {a % b, a / b};
            end
        endcase
    endfunction

    always @(posedge clk) begin
        m_valid <= 1'b0;
        if (rst) begin
            m_busy <= 1'b0;
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else if (m_busy) begin
            if (cancel) begin
                m_busy <= 1'b0;
            end else if (m_left == 1) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b1;
                m_hi    <= m_pend[63:32];
                m_lo    <= m_pend[31:0];
            end else begin
                m_left <= m_left - 1;
            end
        end else if (start && !cancel) begin
            m_pend <= ref_result(op, src_a, src_b);
            m_left <= (op[1] && src_b != 32'd0) ? 33 : 1;
            m_busy <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", 64'(busy), 64'(m_busy));
            chk("cyc_result_valid", 64'(result_valid), 64'(m_valid));
            chk("cyc_hi_lo", {hi_out, lo_out}, {m_hi, m_lo});
        end
    end

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int exp_busy);
        int k;
        int nb;
        @(posedge clk); #1;
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk); #1;
        start = 1'b0;
        nb = 0;
        for (k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (result_valid) break;
            if (busy) nb++;
        end
        chk({name, "_valid_seen"}, 64'(result_valid), 64'd1);
        chk({name, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
        chk({name, "_valid_cycle"}, 64'(k), 64'(exp_busy + 1));
        chk({name, "_hi"}, 64'(hi_out), 64'(exp_hi));
        chk({name, "_lo"}, 64'(lo_out), 64'(exp_lo));
    endtask

    task automatic abort_run(input bit use_rst);
        @(posedge clk); #1;
        start = 1'b1; op = 2'b11; src_a = 32'd1000; src_b = 32'd7;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            start  = (k == 5);
            op     = (k == 5) ? 2'b00 : 2'b11;
            cancel = !use_rst && (k == 10);
            rst    = use_rst && (k == 10);
            @(negedge clk);
            chk("abort_busy", 64'(busy), 64'(k <= 10));
            chk("abort_valid", 64'(result_valid), 64'd0);
            if (k == 11)
                chk("abort_hi_lo", {hi_out, lo_out},
                    use_rst ? 64'h0 : 64'h0000_0001_0000_0002);
            @(posedge clk); #1;
        end
        start = 1'b0; cancel = 1'b0; rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_valid", 64'(result_valid), 64'd0);
        chk("reset_hi_lo", {hi_out, lo_out}, 64'd0);

        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1);
        run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1);
        run_op("mult_minsq", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1);
        run_op("div_m7_2",  2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        run_op("div_7_m2",  2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33);
        run_op("divu_by0",  2'b11, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1);
        run_op("div_by0",   2'b10, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1);
        run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33);
        run_op("divu_1000", 2'b11, 32'd1000,      32'd7,         32'd6,         32'd142,       33);
        run_op("multu_set", 2'b01, 32'd2,         32'h8000_0001, 32'h0000_0001, 32'h0000_0002, 1);

        abort_run(1'b0);

        // start and cancel together in IDLE: not accepted
        @(posedge clk); #1;
        start = 1'b1; cancel = 1'b1; op = 2'b01; src_a = 32'd3; src_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b0;
        @(negedge clk);
        chk("idle_cancel_busy", 64'(busy), 64'd0);

        // cancel on the edge a multiply would complete: no write
        @(posedge clk); #1;
        start = 1'b1; op = 2'b00; src_a = 32'd3; src_b = 32'd3;
        @(posedge clk); #1;
        start = 1'b0; cancel = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0;
        @(negedge clk);
        chk("mul_cancel_valid", 64'(result_valid), 64'd0);
        chk("mul_cancel_hi_lo", {hi_out, lo_out}, 64'h0000_0001_0000_0002);

        abort_run(1'b1);

        run_op("after_rst", 2'b11, 32'd1000, 32'd7, 32'd6, 32'd142, 33);
        repeat (3) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
